hazard_scoreboard: RTL and testbench

Parametrised, stateful hazard unit for the MIPS pipeline. It generalises the single-stage load-use check and the MEM-only rs forward to:
- both source operands (rs and rt);
- any pipeline depth;
- per-instruction result latency (ALU, load, multi-cycle ops).

It sits beside decode. It records each issuing writer and ages it every advancing cycle. It tells decode when to stall and which stage to forward each operand from.

---
 rtl/mips_pipe_pkg.sv | 21 ++
 rtl/scoreboard_entry.sv | 51 +++++
 rtl/hazard_scoreboard.sv | 88 ++++++++
 tb/tb_hazard_scoreboard.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline constants for decode and the hazard scoreboard: forward-select
// codes, issue-latency codes and the latency clamp applied when a writer is recorded.
package mips_pipe_pkg;

    localparam int FWD_REGFILE = 0;
    localparam int FWD_EX      = 1;
    localparam int FWD_MEM     = 2;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

    // A writer cannot be forwardable before EX, nor later than the last stage ahead of WB.
    function automatic int clamp_lat(input int lat, input int depth);
        if (lat < LAT_ALU)
            return LAT_ALU;
        if (lat > depth - 1)
            return depth - 1;
        return lat;
    endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// Tracking state for one architectural register: whether a writer is in flight,
// how far it has travelled and the stage at which its result becomes forwardable.
module scoreboard_entry
    import mips_pipe_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int LAT_W = 2,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             rec,
    input  logic [LAT_W-1:0] rec_lat,
    output logic             pending,
    output logic [SEL_W-1:0] age,
    output logic [LAT_W-1:0] ready
);

    logic             r_pending;
    logic [SEL_W-1:0] r_age;
    logic [LAT_W-1:0] r_ready;
    logic [LAT_W-1:0] w_lat_clamped;

    assign w_lat_clamped = LAT_W'(clamp_lat(int'(rec_lat), DEPTH));

    // A new record outranks the aging of an older writer to the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_age     <= '0;
            r_ready   <= '0;
        end else if (rec) begin
            r_pending <= 1'b1;
            r_age     <= SEL_W'(1);
            r_ready   <= w_lat_clamped;
        end else if (adv && r_pending) begin
            if (r_age == SEL_W'(DEPTH - 1)) begin
                r_pending <= 1'b0;
                r_age     <= '0;
            end else begin
                r_age <= r_age + 1'b1;
            end
        end
    end

    assign pending = r_pending;
    assign age     = r_age;
    assign ready   = r_ready;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard unit: records in-flight writers per register, and from that
// state derives the decode stall and the forward stage for both source operands.
module hazard_scoreboard
    import mips_pipe_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int LAT_W    = 2,
    parameter int SEL_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_hold,
    input  logic              issue_valid,
    input  logic              issue_kill,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic [LAT_W-1:0]  issue_lat,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rs_used,
    input  logic              rt_used,
    output logic              stall,
    output logic [SEL_W-1:0]  rs_fwd_sel,
    output logic [SEL_W-1:0]  rt_fwd_sel,
    output logic [31:0]       stall_count
);

    logic              w_adv;
    logic              w_rec;
    logic              w_hit_rs;
    logic              w_hit_rt;
    logic              w_wait_rs;
    logic              w_wait_rt;
    logic              w_stall;
    logic [NUM_REGS-1:0] w_pending;
    logic [SEL_W-1:0]  w_age   [NUM_REGS];
    logic [LAT_W-1:0]  w_ready [NUM_REGS];
    logic [31:0]       r_stall_count;

    assign w_adv = ~pipe_hold;
    assign w_rec = w_adv & issue_valid & ~issue_kill & issue_we
                 & (issue_dst != '0) & ~w_stall;

    // Register 0 is hardwired zero and so never carries a hazard.
    assign w_pending[0] = 1'b0;
    assign w_age[0]     = '0;
    assign w_ready[0]   = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        scoreboard_entry #(
            .DEPTH (DEPTH),
            .LAT_W (LAT_W),
            .SEL_W (SEL_W)
        ) u_entry (
            .clk     (clk),
            .rst     (rst),
            .adv     (w_adv),
            .rec     (w_rec && (issue_dst == ADDR_W'(r))),
            .rec_lat (issue_lat),
            .pending (w_pending[r]),
            .age     (w_age[r]),
            .ready   (w_ready[r])
        );
    end

    // Queries read registered state only, so an issuing instruction never sees itself.
    assign w_hit_rs  = rs_used & w_pending[rs_addr];
    assign w_hit_rt  = rt_used & w_pending[rt_addr];
    assign w_wait_rs = w_hit_rs & (int'(w_age[rs_addr]) < int'(w_ready[rs_addr]));
    assign w_wait_rt = w_hit_rt & (int'(w_age[rt_addr]) < int'(w_ready[rt_addr]));
    assign w_stall   = ~pipe_hold & (w_wait_rs | w_wait_rt);

    assign stall      = w_stall;
    assign rs_fwd_sel = w_hit_rs ? w_age[rs_addr] : SEL_W'(FWD_REGFILE);
    assign rt_fwd_sel = w_hit_rt ? w_age[rt_addr] : SEL_W'(FWD_REGFILE);

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_count <= '0;
        else if (w_stall && (r_stall_count != 32'hFFFF_FFFF))
            r_stall_count <= r_stall_count + 32'd1;
    end

    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of the hazard scoreboard at DEPTH=3 and at DEPTH=5.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_hold, issue_valid, issue_kill, issue_we;
    logic [4:0]  issue_dst, rs_addr, rt_addr;
    logic [1:0]  issue_lat;
    logic        rs_used, rt_used;
    logic        stall;
    logic [1:0]  rs_fwd_sel, rt_fwd_sel;
    logic [31:0] stall_count;

    logic        pipe_hold5, issue_valid5, issue_kill5, issue_we5;
    logic [4:0]  issue_dst5, rs_addr5, rt_addr5;
    logic [2:0]  issue_lat5;
    logic        rs_used5, rt_used5;
    logic        stall5;
    logic [2:0]  rs_fwd_sel5, rt_fwd_sel5;
    logic [31:0] stall_count5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .pipe_hold(pipe_hold), .issue_valid(issue_valid),
        .issue_kill(issue_kill), .issue_we(issue_we), .issue_dst(issue_dst),
        .issue_lat(issue_lat), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_used(rs_used), .rt_used(rt_used), .stall(stall),
        .rs_fwd_sel(rs_fwd_sel), .rt_fwd_sel(rt_fwd_sel), .stall_count(stall_count)
    );

    hazard_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .DEPTH(5), .LAT_W(3), .SEL_W(3)) dut5 (
        .clk(clk), .rst(rst), .pipe_hold(pipe_hold5), .issue_valid(issue_valid5),
        .issue_kill(issue_kill5), .issue_we(issue_we5), .issue_dst(issue_dst5),
        .issue_lat(issue_lat5), .rs_addr(rs_addr5), .rt_addr(rt_addr5),
        .rs_used(rs_used5), .rt_used(rt_used5), .stall(stall5),
        .rs_fwd_sel(rs_fwd_sel5), .rt_fwd_sel(rt_fwd_sel5), .stall_count(stall_count5)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pipe_hold = 0; issue_valid = 0; issue_kill = 0; issue_we = 0;
        issue_dst = 0; issue_lat = 0; rs_addr = 0; rt_addr = 0; rs_used = 0; rt_used = 0;
        pipe_hold5 = 0; issue_valid5 = 0; issue_kill5 = 0; issue_we5 = 0;
        issue_dst5 = 0; issue_lat5 = 0; rs_addr5 = 0; rt_addr5 = 0; rs_used5 = 0; rt_used5 = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step();
        rst = 0;
        #1;
    endtask

    task automatic issue(input logic [4:0] dst, input logic [1:0] lat);
        issue_valid = 1; issue_we = 1; issue_kill = 0; issue_dst = dst; issue_lat = lat;
    endtask

    task automatic no_issue();
        issue_valid = 0; issue_we = 0; issue_kill = 0; issue_dst = 0; issue_lat = 0;
    endtask

    task automatic test_reset();
        do_reset();
        rs_addr = 5; rs_used = 1; rt_addr = 9; rt_used = 1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
        checks++; if (rs_fwd_sel !== 2'd0) begin errors++; $display("FAIL reset_rs_sel: got %0d expected 0", rs_fwd_sel); end
        checks++; if (rt_fwd_sel !== 2'd0) begin errors++; $display("FAIL reset_rt_sel: got %0d expected 0", rt_fwd_sel); end
        checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", stall_count); end
        checks++; if (stall_count5 !== 32'd0) begin errors++; $display("FAIL reset_count5: got %0d expected 0", stall_count5); end
    endtask

    task automatic test_alu_back_to_back();
        do_reset();
        issue(5'd5, 2'd1);
        step();
        no_issue(); rs_addr = 5; rs_used = 1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %0b expected 0", stall); end
        checks++; if (rs_fwd_sel !== 2'd1) begin errors++; $display("FAIL alu_sel_ex: got %0d expected 1", rs_fwd_sel); end
        step();
        checks++; if (rs_fwd_sel !== 2'd2) begin errors++; $display("FAIL alu_sel_mem: got %0d expected 2", rs_fwd_sel); end
        step();
        checks++; if (rs_fwd_sel !== 2'd0) begin errors++; $display("FAIL alu_sel_wb: got %0d expected 0", rs_fwd_sel); end
    endtask

    task automatic test_load_use();
        do_reset();
        issue(5'd8, 2'd2);
        step();
        // The stalled consumer itself writes r10; it must not be recorded until it leaves decode.
        issue(5'd10, 2'd1); rt_addr = 8; rt_used = 1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_stall: got %0b expected 1", stall); end
        checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL load_count0: got %0d expected 0", stall_count); end
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_stall_end: got %0b expected 0", stall); end
        checks++; if (rt_fwd_sel !== 2'd2) begin errors++; $display("FAIL load_rt_sel: got %0d expected 2", rt_fwd_sel); end
        checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL load_count1: got %0d expected 1", stall_count); end
        step();
        no_issue(); rt_used = 0; rs_addr = 10; rs_used = 1; #1;
        checks++; if (rs_fwd_sel !== 2'd1) begin errors++; $display("FAIL load_consumer_rec: got %0d expected 1", rs_fwd_sel); end
        checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL load_count_hold: got %0d expected 1", stall_count); end
    endtask

    task automatic test_zero_unused();
        do_reset();
        issue(5'd0, 2'd2);
        step();
        no_issue(); rs_addr = 0; rs_used = 1; rt_addr = 0; rt_used = 1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %0b expected 0", stall); end
        checks++; if (rs_fwd_sel !== 2'd0) begin errors++; $display("FAIL zero_rs_sel: got %0d expected 0", rs_fwd_sel); end
        rs_used = 0; rt_used = 0;
        issue(5'd8, 2'd2);
        step();
        no_issue(); rs_addr = 8; rs_used = 0; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unused_stall: got %0b expected 0", stall); end
        checks++; if (rs_fwd_sel !== 2'd0) begin errors++; $display("FAIL unused_sel: got %0d expected 0", rs_fwd_sel); end
        rs_used = 1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL used_stall: got %0b expected 1", stall); end
        rs_used = 0;
        step(); step();
        issue(5'd12, 2'd2); issue_kill = 1;
        step();
        no_issue(); rs_addr = 12; rs_used = 1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL kill_stall: got %0b expected 0", stall); end
        checks++; if (rs_fwd_sel !== 2'd0) begin errors++; $display("FAIL kill_sel: got %0d expected 0", rs_fwd_sel); end
        rs_used = 0;
        issue(5'd13, 2'd1); issue_we = 0;
        step();
        no_issue(); rt_addr = 13; rt_used = 1; #1;
        checks++; if (rt_fwd_sel !== 2'd0) begin errors++; $display("FAIL nowe_sel: got %0d expected 0", rt_fwd_sel); end
    endtask

    task automatic test_clamp();
        do_reset();
        issue(5'd6, 2'd3);
        step();
        no_issue(); rs_addr = 6; rs_used = 1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL clamp_hi_stall: got %0b expected 1", stall); end
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL clamp_hi_release: got %0b expected 0", stall); end
        checks++; if (rs_fwd_sel !== 2'd2) begin errors++; $display("FAIL clamp_hi_sel: got %0d expected 2", rs_fwd_sel); end
        rs_used = 0;
        issue(5'd7, 2'd0);
        step();
        no_issue(); rt_addr = 7; rt_used = 1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL clamp_lo_stall: got %0b expected 0", stall); end
        checks++; if (rt_fwd_sel !== 2'd1) begin errors++; $display("FAIL clamp_lo_sel: got %0d expected 1", rt_fwd_sel); end
    endtask

    task automatic test_waw();
        do_reset();
        issue(5'd3, 2'd1);
        step();
        issue(5'd3, 2'd2);
        step();
        no_issue(); rs_addr = 3; rs_used = 1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %0b expected 1", stall); end
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_release: got %0b expected 0", stall); end
        checks++; if (rs_fwd_sel !== 2'd2) begin errors++; $display("FAIL waw_sel: got %0d expected 2", rs_fwd_sel); end
        rs_used = 0;
        issue(5'd4, 2'd1);
        step();
        no_issue();
        step();
        issue(5'd4, 2'd1); rt_addr = 4; rt_used = 1; #1;
        checks++; if (rt_fwd_sel !== 2'd2) begin errors++; $display("FAIL same_cycle_pre: got %0d expected 2", rt_fwd_sel); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL same_cycle_stall: got %0b expected 0", stall); end
        step();
        no_issue(); #1;
        checks++; if (rt_fwd_sel !== 2'd1) begin errors++; $display("FAIL same_cycle_rec: got %0d expected 1", rt_fwd_sel); end
    endtask

    task automatic test_pipe_hold();
        do_reset();
        issue(5'd9, 2'd2);
        step();
        no_issue(); rt_addr = 9; rt_used = 1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_pre_stall: got %0b expected 1", stall); end
        pipe_hold = 1; issue(5'd11, 2'd1); #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_stall[%0d]: got %0b expected 0", i, stall); end
            checks++; if (rt_fwd_sel !== 2'd1) begin errors++; $display("FAIL hold_age[%0d]: got %0d expected 1", i, rt_fwd_sel); end
            step();
        end
        pipe_hold = 0; no_issue(); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_release_stall: got %0b expected 1", stall); end
        checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL hold_count0: got %0d expected 0", stall_count); end
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_after: got %0b expected 0", stall); end
        checks++; if (rt_fwd_sel !== 2'd2) begin errors++; $display("FAIL hold_after_sel: got %0d expected 2", rt_fwd_sel); end
        checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL hold_count1: got %0d expected 1", stall_count); end
        rs_addr = 11; rs_used = 1; #1;
        checks++; if (rs_fwd_sel !== 2'd0) begin errors++; $display("FAIL hold_no_rec: got %0d expected 0", rs_fwd_sel); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        issue(5'd8, 2'd2);
        step();
        issue(5'd14, 2'd1); rt_addr = 8; rt_used = 1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rms_pre: got %0b expected 1", stall); end
        rst = 1;
        step();
        rst = 0; no_issue(); rs_addr = 8; rs_used = 1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rms_stall: got %0b expected 0", stall); end
        checks++; if (rs_fwd_sel !== 2'd0) begin errors++; $display("FAIL rms_rs_sel: got %0d expected 0", rs_fwd_sel); end
        checks++; if (rt_fwd_sel !== 2'd0) begin errors++; $display("FAIL rms_rt_sel: got %0d expected 0", rt_fwd_sel); end
        checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL rms_count: got %0d expected 0", stall_count); end
        rs_used = 0; rt_used = 0;
        issue(5'd15, 2'd1); pipe_hold = 1; rst = 1;
        step();
        rst = 0; pipe_hold = 0; no_issue(); rs_addr = 15; rs_used = 1; #1;
        checks++; if (rs_fwd_sel !== 2'd0) begin errors++; $display("FAIL rst_over_issue: got %0d expected 0", rs_fwd_sel); end
    endtask

    task automatic test_depth5();
        do_reset();
        issue_valid5 = 1; issue_we5 = 1; issue_dst5 = 20; issue_lat5 = 4;
        step();
        issue_valid5 = 0; issue_we5 = 0; rs_addr5 = 20; rs_used5 = 1; #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (stall5 !== 1'b1) begin errors++; $display("FAIL d5_stall[%0d]: got %0b expected 1", i, stall5); end
            step();
        end
        checks++; if (stall5 !== 1'b0) begin errors++; $display("FAIL d5_release: got %0b expected 0", stall5); end
        checks++; if (rs_fwd_sel5 !== 3'd4) begin errors++; $display("FAIL d5_sel: got %0d expected 4", rs_fwd_sel5); end
        checks++; if (stall_count5 !== 32'd3) begin errors++; $display("FAIL d5_count: got %0d expected 3", stall_count5); end
        step();
        checks++; if (rs_fwd_sel5 !== 3'd0) begin errors++; $display("FAIL d5_wb_sel: got %0d expected 0", rs_fwd_sel5); end
        rs_used5 = 0;
        issue_valid5 = 1; issue_we5 = 1; issue_dst5 = 21; issue_lat5 = 4;
        step();
        issue_valid5 = 0; issue_we5 = 0; rt_addr5 = 21; rt_used5 = 1;
        step();
        checks++; if (stall5 !== 1'b1) begin errors++; $display("FAIL d5_rms_pre: got %0b expected 1", stall5); end
        rst = 1;
        step();
        rst = 0; #1;
        checks++; if (stall5 !== 1'b0) begin errors++; $display("FAIL d5_rms_stall: got %0b expected 0", stall5); end
        checks++; if (rt_fwd_sel5 !== 3'd0) begin errors++; $display("FAIL d5_rms_sel: got %0d expected 0", rt_fwd_sel5); end
        checks++; if (stall_count5 !== 32'd0) begin errors++; $display("FAIL d5_rms_count: got %0d expected 0", stall_count5); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_alu_back_to_back();
        test_load_use();
        test_zero_unused();
        test_clamp();
        test_waw();
        test_pipe_hold();
        test_reset_mid_stall();
        test_depth5();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
